// File: rtl/vec_pipe_ctrl_if.sv
// rtl/vec_pipe_ctrl_if.sv - decode, EX-unit and register-file signals of vec_pipe_ctrl
interface vec_pipe_ctrl_if #(
  parameter int OPCODE_W   = 5,
  parameter int REG_ADDR_W = 4
);
  logic                  dec_valid;
  logic [OPCODE_W-1:0]   dec_opcode;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic                  dec_ready;
  logic                  alu_st;
  logic [3:0]            alu_op;
  logic                  mem_st;
  logic [1:0]            mem_op;
  logic                  alu_rdy;
  logic                  mem_rdy;
  logic                  shift_op;
  logic [1:0]            esc_wr_sel;
  logic [1:0]            vec_wr_sel;
  logic                  esc_wr_en;
  logic                  vec_wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic                  busy;
  logic                  halted;
  logic                  timeout_err;

  modport master (
    output dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2, alu_rdy, mem_rdy,
    input  dec_ready, alu_st, alu_op, mem_st, mem_op, shift_op, esc_wr_sel, vec_wr_sel,
           esc_wr_en, vec_wr_en, wr_addr, busy, halted, timeout_err
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2, alu_rdy, mem_rdy,
    output dec_ready, alu_st, alu_op, mem_st, mem_op, shift_op, esc_wr_sel, vec_wr_sel,
           esc_wr_en, vec_wr_en, wr_addr, busy, halted, timeout_err
  );
endinterface

// File: rtl/vec_pipe_ctrl.sv
// rtl/vec_pipe_ctrl.sv - sequential vector control: issue, wait with timeout, RAW hazard, writeback
module vec_pipe_ctrl #(
  parameter int OPCODE_W    = 5,
  parameter int REG_ADDR_W  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input logic            clk,
  input logic            rst,
  vec_pipe_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [4:0] OP_ALU_MAX = 5'h0D;
  localparam logic [4:0] OP_CV      = 5'h0E;
  localparam logic [4:0] OP_CE      = 5'h0F;
  localparam logic [4:0] OP_GE      = 5'h11;
  localparam logic [4:0] OP_TB      = 5'h12;
  localparam logic [4:0] OP_CDE     = 5'h13;
  localparam logic [4:0] OP_CIE     = 5'h14;
  localparam logic [4:0] OP_SI      = 5'h15;
  localparam logic [4:0] OP_CI      = 5'h16;
  localparam logic [4:0] OP_STP     = 5'h1F;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  alu_st_q, alu_st_d;
  logic                  mem_st_q, mem_st_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic [1:0]            mem_op_q, mem_op_d;
  logic                  wait_alu_q, wait_alu_d;
  logic                  pend_esc_q, pend_esc_d;
  logic                  pend_vec_q, pend_vec_d;
  logic                  esc_en_q, esc_en_d;
  logic                  vec_en_q, vec_en_d;
  logic [1:0]            esc_sel_q, esc_sel_d;
  logic [1:0]            vec_sel_q, vec_sel_d;
  logic                  shift_q, shift_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic                  tout_q, tout_d;

  logic [OPCODE_W-1:0]   opc;
  logic [4:0]            op5;
  logic                  is_alu, is_mem, is_sgl, is_stp;
  logic                  hazard, ready, accept, rdy;

  assign opc    = bus.dec_opcode;
  assign op5    = opc[4:0];
  assign is_alu = (op5 <= OP_ALU_MAX);
  assign is_mem = (op5 >= OP_CV) && (op5 <= OP_GE);
  assign is_sgl = (op5 >= OP_TB) && (op5 <= OP_CI);
  assign is_stp = (op5 == OP_STP);

  // A write enable being high this cycle is the only pending writeback there can be.
  assign hazard = (esc_en_q || vec_en_q) && bus.dec_valid &&
                  ((bus.dec_rs1 == wr_addr_q) || (bus.dec_rs2 == wr_addr_q));
  assign ready  = (state_q == S_IDLE) && !hazard;
  assign accept = bus.dec_valid && ready;
  assign rdy    = wait_alu_q ? bus.alu_rdy : bus.mem_rdy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_st_d   = 1'b0;
    mem_st_d   = 1'b0;
    esc_en_d   = 1'b0;
    vec_en_d   = 1'b0;
    alu_op_d   = alu_op_q;
    mem_op_d   = mem_op_q;
    wait_alu_d = wait_alu_q;
    pend_esc_d = pend_esc_q;
    pend_vec_d = pend_vec_q;
    esc_sel_d  = esc_sel_q;
    vec_sel_d  = vec_sel_q;
    shift_d    = shift_q;
    wr_addr_d  = wr_addr_q;
    tout_d     = tout_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_sgl) begin
            wr_addr_d = bus.dec_rd;
            case (op5)
              OP_TB:   begin vec_en_d = 1'b1; vec_sel_d = 2'd2; end
              OP_CDE:  begin esc_en_d = 1'b1; esc_sel_d = 2'd2; shift_d = 1'b1; end
              OP_CIE:  begin esc_en_d = 1'b1; esc_sel_d = 2'd2; shift_d = 1'b0; end
              OP_SI:   begin esc_en_d = 1'b1; esc_sel_d = 2'd3; end
              default: begin esc_en_d = 1'b1; esc_sel_d = 2'd0; end
            endcase
          end else if (is_alu || is_mem) begin
            state_d    = S_ISSUE;
            wr_addr_d  = bus.dec_rd;
            wait_alu_d = is_alu;
            alu_st_d   = is_alu;
            mem_st_d   = is_mem;
            pend_esc_d = 1'b0;
            pend_vec_d = 1'b0;
            if (is_alu) begin
              alu_op_d   = op5[3:0];
              vec_sel_d  = 2'd1;
              pend_vec_d = 1'b1;
            end else begin
              mem_op_d = op5[1:0];
              if (op5 == OP_CV) begin
                vec_sel_d  = 2'd0;
                pend_vec_d = 1'b1;
              end else if (op5 == OP_CE) begin
                esc_sel_d  = 2'd1;
                pend_esc_d = 1'b1;
              end
            end
          end else if (is_stp) begin
            state_d = S_HALT;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (rdy) begin
          state_d  = S_IDLE;
          esc_en_d = pend_esc_q;
          vec_en_d = pend_vec_q;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_st_q   <= 1'b0;
      mem_st_q   <= 1'b0;
      alu_op_q   <= '0;
      mem_op_q   <= '0;
      wait_alu_q <= 1'b0;
      pend_esc_q <= 1'b0;
      pend_vec_q <= 1'b0;
      esc_en_q   <= 1'b0;
      vec_en_q   <= 1'b0;
      esc_sel_q  <= '0;
      vec_sel_q  <= '0;
      shift_q    <= 1'b0;
      wr_addr_q  <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_st_q   <= alu_st_d;
      mem_st_q   <= mem_st_d;
      alu_op_q   <= alu_op_d;
      mem_op_q   <= mem_op_d;
      wait_alu_q <= wait_alu_d;
      pend_esc_q <= pend_esc_d;
      pend_vec_q <= pend_vec_d;
      esc_en_q   <= esc_en_d;
      vec_en_q   <= vec_en_d;
      esc_sel_q  <= esc_sel_d;
      vec_sel_q  <= vec_sel_d;
      shift_q    <= shift_d;
      wr_addr_q  <= wr_addr_d;
      tout_q     <= tout_d;
    end
  end

  assign bus.dec_ready   = ready;
  assign bus.alu_st      = alu_st_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.mem_st      = mem_st_q;
  assign bus.mem_op      = mem_op_q;
  assign bus.shift_op    = shift_q;
  assign bus.esc_wr_sel  = esc_sel_q;
  assign bus.vec_wr_sel  = vec_sel_q;
  assign bus.esc_wr_en   = esc_en_q;
  assign bus.vec_wr_en   = vec_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.busy        = (state_q != S_IDLE) || esc_en_q || vec_en_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.timeout_err = tout_q;
endmodule
